// File: rtl/bf16_add_sequencer_if.sv
// Handshake bundle between the operand source, the external bf16 adder and
// the result sink. "slave" is the sequencer's view, "master" the environment's.
interface bf16_add_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_ready;
  logic [15:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        err_timeout;

  modport slave (
    input  in_valid, in_a, in_b, add_ready, add_sum, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, err_timeout
  );

  modport master (
    output in_valid, in_a, in_b, add_ready, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, err_timeout
  );
endinterface

// File: rtl/bf16_add_sequencer.sv
// Operand-pair FIFO feeding an external bf16 adder one pair at a time.
// Results are captured and held for a ready/valid sink; a stalled adder
// handshake is abandoned after TIMEOUT cycles and flagged in err_timeout.
// Values are treated as opaque 16-bit words.
module bf16_add_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic                   clock,
  input logic                   nreset,
  bf16_add_sequencer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [31:0]       head;

  logic [TW-1:0]     timer_reg;
  logic [15:0]       add_a_reg;
  logic [15:0]       add_b_reg;
  logic [15:0]       out_sum_reg;
  logic              out_valid_reg;
  logic              err_reg;

  logic              push;
  logic              pop;
  logic              timer_clear;
  logic              timer_inc;
  logic              capture;
  logic              out_done;
  logic              timeout_hit;

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens a slot for a push.
  assign bus.in_ready = (count_reg < FULL_COUNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr_reg];

  assign bus.add_a       = add_a_reg;
  assign bus.add_b       = add_b_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_sum     = out_sum_reg;
  assign bus.err_timeout = err_reg;

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.in_a, bus.in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control strobes; an adder ack wins over a coincident timeout.
  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    capture     = 1'b0;
    out_done    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((count_reg != '0) && bus.add_ready) begin
          pop         = 1'b1;
          timer_clear = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.add_ready) begin
          timer_clear = 1'b1;
          state_next  = WAIT;
        end else if (timer_reg == TIMER_MAX) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT: begin
        if (bus.add_ready) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (timer_reg == TIMER_MAX) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake timer, cleared at each phase entry.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      timer_reg <= '0;
    end else if (timer_clear) begin
      timer_reg <= '0;
    end else if (timer_inc) begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  // Operand registers: loaded only at pop so they stay put for the whole transaction.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      add_a_reg <= '0;
      add_b_reg <= '0;
    end else if (pop) begin
      add_a_reg <= head[31:16];
      add_b_reg <= head[15:0];
    end
  end

  // Result capture/hold and the sticky timeout flag.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_sum_reg   <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (capture) begin
        out_sum_reg   <= bus.add_sum;
        out_valid_reg <= 1'b1;
      end else if (out_done) begin
        out_valid_reg <= 1'b0;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bf16_add_sequencer.sv
// Directed bench: the bench plays both the operand source and the adder.
module tb_bf16_add_sequencer;

  logic clock;
  logic nreset;
  int   checks   = 0;
  int   failures = 0;

  bf16_add_sequencer_if bus();

  bf16_add_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // One full transaction starting in IDLE with the head pair queued.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s);
    bus.add_ready = 1'b1;
    tick();
    chk({tag, "_add_a"}, 32'(bus.add_a), 32'(a));
    chk({tag, "_add_b"}, 32'(bus.add_b), 32'(b));
    bus.add_ready = 1'b0;
    tick();
    bus.add_sum   = s;
    bus.add_ready = 1'b1;
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.out_sum), 32'(s));
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_clear"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  logic [15:0] fa [4] = '{16'h3F80, 16'h4000, 16'h4040, 16'hBF80};
  logic [15:0] fb [4] = '{16'h3F80, 16'h4000, 16'h3F80, 16'h3F80};
  logic [15:0] fs [4] = '{16'h4000, 16'h4080, 16'h4080, 16'h0000};

  int          pushed;
  int          got;
  int          cyc;
  logic        ar;
  logic        saw_valid;
  logic [15:0] want_sum;

  initial begin
    // ---------------- reset ----------------
    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.add_ready = 1'b1;
    bus.add_sum   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'h0);
    chk("rst_add_b", 32'(bus.add_b), 32'h0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'h0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    nreset = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_count", 32'(dut.count_reg), 32'd0);

    // ---------------- single pair, minimum latency ----------------
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h3F80;
    bus.in_b     = 16'h4000;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_count_after_push", 32'(dut.count_reg), 32'd1);
    chk("t1_no_early_pop", 32'(bus.add_a), 32'h0);
    tick();
    chk("t1_pop_a", 32'(bus.add_a), 32'h3F80);
    chk("t1_pop_b", 32'(bus.add_b), 32'h4000);
    chk("t1_count_after_pop", 32'(dut.count_reg), 32'd0);
    bus.add_ready = 1'b0;
    tick();
    chk("t1_not_valid_in_wait", 32'(bus.out_valid), 32'd0);
    bus.add_sum   = 16'h4040;
    bus.add_ready = 1'b1;
    tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_sum", 32'(bus.out_sum), 32'h4040);
    bus.add_sum = 16'h1234;
    repeat (3) tick();
    chk("t1_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_hold_sum", 32'(bus.out_sum), 32'h4040);
    chk("t1_hold_add_a", 32'(bus.add_a), 32'h3F80);
    chk("t1_hold_add_b", 32'(bus.add_b), 32'h4000);
    bus.out_ready = 1'b1;
    tick();
    chk("t1_release", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // ---------------- fill to DEPTH, reject 5th, drain in order ----------------
    bus.add_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = fa[i];
      bus.in_b     = fb[i];
      tick();
    end
    chk("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_full_count", 32'(dut.count_reg), 32'd4);
    bus.in_a = 16'h4100;
    bus.in_b = 16'h4100;
    tick();
    bus.in_valid = 1'b0;
    chk("t2_fifth_rejected", 32'(dut.count_reg), 32'd4);
    for (int i = 0; i < 4; i++) begin
      run_one($sformatf("t2_drain%0d", i), fa[i], fb[i], fs[i]);
    end
    chk("t2_empty", 32'(dut.count_reg), 32'd0);

    // ---------------- simultaneous push/pop at count=2 ----------------
    bus.add_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a = 16'h4120; bus.in_b = 16'h3F80; tick();
    bus.in_a = 16'h4200; bus.in_b = 16'h4200; tick();
    chk("t4_count2", 32'(dut.count_reg), 32'd2);
    bus.in_a = 16'hC000; bus.in_b = 16'h4000;
    bus.add_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_count_unchanged", 32'(dut.count_reg), 32'd2);
    chk("t4_pop_a", 32'(bus.add_a), 32'h4120);
    bus.add_ready = 1'b0;
    tick();
    bus.add_sum   = 16'h4130;
    bus.add_ready = 1'b1;
    tick();
    chk("t4_first_sum", 32'(bus.out_sum), 32'h4130);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    run_one("t4_second", 16'h4200, 16'h4200, 16'h4280);
    run_one("t4_third", 16'hC000, 16'h4000, 16'h0000);

    // ---------------- streamed ordering with stalls ----------------
    pushed = 0;
    got    = 0;
    cyc    = 0;
    ar     = 1'b0;
    while (got < 10 && cyc < 2000) begin
      bus.in_valid  = (pushed < 10) && ($urandom_range(0, 3) != 0);
      bus.in_a      = 16'h1000 + 16'(pushed) * 16'h0111;
      bus.in_b      = 16'h0200 + 16'(pushed);
      ar            = ~ar;
      bus.add_ready = ar;
      bus.add_sum   = bus.add_a + bus.add_b;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) pushed++;
      if (bus.out_valid && bus.out_ready) begin
        want_sum = (16'h1000 + 16'(got) * 16'h0111) + (16'h0200 + 16'(got));
        chk($sformatf("t3_result%0d", got), 32'(bus.out_sum), 32'(want_sum));
        got++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.add_ready = 1'b1;
    chk("t3_result_count", 32'(got), 32'd10);
    chk("t3_all_pushed", 32'(pushed), 32'd10);
    chk("t3_empty", 32'(dut.count_reg), 32'd0);
    tick();
    chk("t3_no_extra_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_no_err", 32'(bus.err_timeout), 32'd0);

    // ---------------- timeout in ISSUE ----------------
    bus.in_valid = 1'b1;
    bus.in_a = 16'h4040; bus.in_b = 16'h4040;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t5_pop_a", 32'(bus.add_a), 32'h4040);
    repeat (12) tick();
    chk("t5_err_not_yet", 32'(bus.err_timeout), 32'd0);
    repeat (8) tick();
    chk("t5_err_set", 32'(bus.err_timeout), 32'd1);
    chk("t5_no_result", 32'(bus.out_valid), 32'd0);
    chk("t5_empty", 32'(dut.count_reg), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a = 16'h3F00; bus.in_b = 16'h3F00;
    tick();
    bus.in_valid = 1'b0;
    run_one("t5_next", 16'h3F00, 16'h3F00, 16'h3F80);
    chk("t5_err_sticky", 32'(bus.err_timeout), 32'd1);

    // ---------------- reset mid-flight ----------------
    bus.add_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a = 16'h4500; bus.in_b = 16'h4501; tick();
    bus.in_a = 16'h4600; bus.in_b = 16'h4601; tick();
    bus.in_a = 16'h4700; bus.in_b = 16'h4701; tick();
    bus.in_valid  = 1'b0;
    bus.add_ready = 1'b1;
    tick();
    bus.add_ready = 1'b0;
    tick();
    chk("t6_queued", 32'(dut.count_reg), 32'd2);
    nreset = 1'b0;
    #1;
    chk("t6_rst_add_a", 32'(bus.add_a), 32'h0);
    chk("t6_rst_add_b", 32'(bus.add_b), 32'h0);
    chk("t6_rst_out_sum", 32'(bus.out_sum), 32'h0);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_err", 32'(bus.err_timeout), 32'd0);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_rst_count", 32'(dut.count_reg), 32'd0);
    tick();
    nreset        = 1'b1;
    bus.out_ready = 1'b1;
    bus.add_sum   = 16'h7777;
    saw_valid     = 1'b0;
    ar            = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ar            = ~ar;
      bus.add_ready = ar;
      tick();
      if (bus.out_valid) saw_valid = 1'b1;
    end
    chk("t6_no_result_after_release", 32'(saw_valid), 32'd0);
    chk("t6_count_after_release", 32'(dut.count_reg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
